// File: rtl/prbs31_sync_checker.sv
// prbs31_sync_checker
// Self-synchronising PRBS31 receive checker (b[n] = b[n-31] ^ b[n-28]).
// A FILL/SEARCH/LOCKED FSM acquires the sequence, then counts locked bits and
// bit errors. Lock is dropped when too many errors land in one window. The
// checker then re-acquires the sequence, and each loss of lock is counted.
module prbs31_sync_checker #(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW_LEN  = 1024,
    parameter int LOSS_THRESH = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        data_in,
    input  logic        data_in_valid,
    input  logic        clear,
    output logic        locked,
    output logic        bit_error,
    output logic [31:0] total_bits,
    output logic [31:0] total_bit_errors,
    output logic [15:0] relock_count
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(WINDOW_LEN + 1);
    localparam int EW = $clog2(LOSS_THRESH + 1);

    localparam logic [MW-1:0] MATCH_LAST  = MW'(LOCK_COUNT - 1);
    localparam logic [WW-1:0] WIN_LAST    = WW'(WINDOW_LEN - 1);
    localparam logic [EW:0]   LOSS_THRESH_C = (EW + 1)'(LOSS_THRESH);

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SEARCH = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [30:0]     sr_q, sr_d;
    logic [4:0]      fill_q, fill_d;
    logic [MW-1:0]   match_q, match_d;
    logic [WW-1:0]   winb_q, winb_d;
    logic [EW-1:0]   wine_q, wine_d;
    logic [31:0]     tbits_q, tbits_d;
    logic [31:0]     terrs_q, terrs_d;
    logic [15:0]     relock_q, relock_d;
    logic            berr_q, berr_d;

    logic            pred;
    logic            err;
    logic [EW:0]     errs_sum;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    // sr[0] is the newest bit, so sr[30] is b[n-31] and sr[27] is b[n-28].
    assign pred     = sr_q[30] ^ sr_q[27];
    assign err      = data_in ^ pred;
    assign errs_sum = {1'b0, wine_q} + {{EW{1'b0}}, err};

    assign locked           = (state_q == LOCKED);
    assign bit_error        = berr_q;
    assign total_bits       = tbits_q;
    assign total_bit_errors = terrs_q;
    assign relock_count     = relock_q;

    // Next-state logic: FSM, shift register, window and statistics counters.
    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        fill_d   = fill_q;
        match_d  = match_q;
        winb_d   = winb_q;
        wine_d   = wine_q;
        tbits_d  = tbits_q;
        terrs_d  = terrs_q;
        relock_d = relock_q;
        berr_d   = 1'b0;

        if (data_in_valid) begin
            case (state_q)
                FILL: begin
                    sr_d = {sr_q[29:0], data_in};
                    if (fill_q == 5'd30) begin
                        fill_d  = 5'd0;
                        state_d = SEARCH;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                SEARCH: begin
                    // Load the received bit so that a wrong seed is flushed out.
                    sr_d = {sr_q[29:0], data_in};
                    if (!err) begin
                        if (match_q == MATCH_LAST) begin
                            match_d = '0;
                            winb_d  = '0;
                            wine_d  = '0;
                            state_d = LOCKED;
                        end else begin
                            match_d = match_q + MW'(1);
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so one line error counts only once.
                    sr_d    = {sr_q[29:0], pred};
                    tbits_d = sat_inc32(tbits_q);
                    berr_d  = err;
                    if (err) begin
                        terrs_d = sat_inc32(terrs_q);
                        wine_d  = wine_q + EW'(1);
                    end
                    if (winb_q == WIN_LAST) begin
                        winb_d = '0;
                        wine_d = '0;
                    end else begin
                        winb_d = winb_q + WW'(1);
                    end
                    if (errs_sum >= LOSS_THRESH_C) begin
                        state_d  = FILL;
                        relock_d = sat_inc16(relock_q);
                        match_d  = '0;
                        fill_d   = 5'd0;
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = 5'd0;
                    match_d = '0;
                end
            endcase
        end

        // Clear wins over the bit presented in the same cycle.
        if (clear) begin
            tbits_d = '0;
            terrs_d = '0;
        end
    end

    // State and counter registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FILL;
            sr_q     <= '0;
            fill_q   <= '0;
            match_q  <= '0;
            winb_q   <= '0;
            wine_q   <= '0;
            tbits_q  <= '0;
            terrs_q  <= '0;
            relock_q <= '0;
            berr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            fill_q   <= fill_d;
            match_q  <= match_d;
            winb_q   <= winb_d;
            wine_q   <= wine_d;
            tbits_q  <= tbits_d;
            terrs_q  <= terrs_d;
            relock_q <= relock_d;
            berr_q   <= berr_d;
        end
    end

endmodule

// File: tb/tb_prbs31_sync_checker.sv
// Testbench for prbs31_sync_checker: phase table plus hand-written sequences
// for acquisition latency, clear and asynchronous reset.
module tb_prbs31_sync_checker;

    logic        clk;
    logic        rstn;
    logic        data_in;
    logic        data_in_valid;
    logic        clear;
    logic        locked;
    logic        bit_error;
    logic [31:0] total_bits;
    logic [31:0] total_bit_errors;
    logic [15:0] relock_count;

    int checks = 0;
    int errors = 0;

    logic [30:0] g = 31'h2A5C_1D37;

    typedef struct {
        int nbits;
        bit gaps;
        int inv_off;
        int inv_len;
        bit exp_locked;
        int exp_tb;
        int exp_te;
        int exp_rl;
        int exp_pulses;
    } phase_t;

    phase_t ph [9];

    prbs31_sync_checker dut (
        .clk              (clk),
        .rstn             (rstn),
        .data_in          (data_in),
        .data_in_valid    (data_in_valid),
        .clear            (clear),
        .locked           (locked),
        .bit_error        (bit_error),
        .total_bits       (total_bits),
        .total_bit_errors (total_bit_errors),
        .relock_count     (relock_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit gen_bit();
        bit b;
        b = g[30] ^ g[27];
        g = {g[29:0], b};
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // One cycle: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic drive(input bit v, input bit inv, input bit clr);
        @(negedge clk);
        data_in_valid = v;
        clear         = clr;
        if (v) data_in = gen_bit() ^ inv;
        else   data_in = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
    endtask

    task automatic send_valid(input int n, input bit gaps);
        int sent;
        bit v;
        sent = 0;
        while (sent < n) begin
            v = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            drive(v, 1'b0, 1'b0);
            if (v) sent++;
        end
    endtask

    // Locked must rise exactly on the 95th valid bit after reset or loss.
    task automatic acquire(input bit gaps, input string tag);
        send_valid(94, gaps);
        chk({tag, "_locked_at_94"}, 32'(locked), 32'd0);
        send_valid(1, gaps);
        chk({tag, "_locked_at_95"}, 32'(locked), 32'd1);
        chk({tag, "_tb_at_lock"}, total_bits, 32'd0);
    endtask

    task automatic run_phase(input int i);
        int  sent;
        int  pulses;
        int  chg;
        bit  v;
        bit  inv;
        logic [31:0] tb_before;
        sent = 0; pulses = 0; chg = 0;
        while (sent < ph[i].nbits) begin
            v   = ph[i].gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            inv = v && (sent >= ph[i].inv_off) && (sent < ph[i].inv_off + ph[i].inv_len);
            tb_before = total_bits;
            drive(v, inv, 1'b0);
            if (bit_error) pulses++;
            if (!v && (total_bits != tb_before || bit_error)) chg++;
            if (v) sent++;
        end
        chk($sformatf("ph%0d_locked", i), 32'(locked), 32'(ph[i].exp_locked));
        chk($sformatf("ph%0d_total_bits", i), total_bits, 32'(ph[i].exp_tb));
        chk($sformatf("ph%0d_total_errs", i), total_bit_errors, 32'(ph[i].exp_te));
        chk($sformatf("ph%0d_relock", i), 32'(relock_count), 32'(ph[i].exp_rl));
        chk($sformatf("ph%0d_pulses", i), 32'(pulses), 32'(ph[i].exp_pulses));
        if (ph[i].gaps) chk($sformatf("ph%0d_idle_changes", i), 32'(chg), 32'd0);
    endtask

    initial begin
        //          nbits gaps off len lk  tb     te  rl pulses
        ph[0] = '{10000, 0,   0,  0,  1, 10000,  0, 0,  0};  // clean stream
        ph[1] = '{  100, 0,  50,  1,  1, 10100,  1, 0,  1};  // single error
        ph[2] = '{  140, 0,   0,  0,  1, 10240,  1, 0,  0};  // run to window edge
        ph[3] = '{   63, 0,   0, 63,  1, 10303, 64, 0, 63};  // burst, still locked
        ph[4] = '{    1, 0,   0,  1,  0, 10304, 65, 1,  1};  // 64th error drops lock
        ph[5] = '{   94, 0,   0,  0,  0, 10304, 65, 1,  0};  // re-acquiring
        ph[6] = '{    1, 0,   0,  0,  1, 10304, 65, 1,  0};  // relock on 95th
        ph[7] = '{10000, 1,   0,  0,  1, 20304, 65, 1,  0};  // 50% valid gaps
        ph[8] = '{10000, 1,   0,  0,  1, 10000,  0, 0,  0};  // after mid-lock reset

        rstn = 1'b0; data_in = 1'b0; data_in_valid = 1'b0; clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_bit_error", 32'(bit_error), 32'd0);
        chk("rst_total_bits", total_bits, 32'd0);
        chk("rst_total_errs", total_bit_errors, 32'd0);
        chk("rst_relock", 32'(relock_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        acquire(1'b0, "acq");
        for (int i = 0; i < 8; i++) run_phase(i);

        // clear with a valid bit: totals zero, that bit discarded
        drive(1'b1, 1'b0, 1'b1);
        chk("clr_total_bits", total_bits, 32'd0);
        chk("clr_total_errs", total_bit_errors, 32'd0);
        chk("clr_locked", 32'(locked), 32'd1);
        send_valid(10, 1'b0);
        chk("clr_resume_bits", total_bits, 32'd10);

        // asynchronous reset mid-lock, right after an error pulse
        drive(1'b1, 1'b1, 1'b0);
        chk("pre_rst_bit_error", 32'(bit_error), 32'd1);
        rstn = 1'b0;
        #1;
        chk("arst_locked", 32'(locked), 32'd0);
        chk("arst_bit_error", 32'(bit_error), 32'd0);
        chk("arst_total_bits", total_bits, 32'd0);
        chk("arst_total_errs", total_bit_errors, 32'd0);
        chk("arst_relock", 32'(relock_count), 32'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;

        acquire(1'b1, "reacq");
        run_phase(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
